mux2x1_arbiter: RTL and testbench

MUX2X1_ARBITER -- requirements
Module: mux2x1_arbiter

---
 rtl/mux2x1_pkg.sv | 20 ++
 rtl/mux2x1_arbiter_if.sv | 44 ++++
 rtl/mux2x1_bus.sv | 26 ++
 rtl/mux2x1_arbiter.sv | 101 ++++++++++
 tb/tb_mux2x1_arbiter.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mux2x1_pkg.sv
// Shared types and constants for the 2:1 packet arbiter.
package mux2x1_pkg;

   // Arbiter FSM: wait for a request, or hold a grant until a last beat transfers.
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_A = 2'd1,
      GRANT_B = 2'd2
   } state_e;

   // Grant encoding as seen on the select output.
   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // Map a grant encoding to its GRANT state.
   function automatic state_e grant_state(input logic sel);
      return (sel == SEL_B) ? GRANT_B : GRANT_A;
   endfunction

endpackage

// File: rtl/mux2x1_arbiter_if.sv
// Handshake bundle for the 2:1 arbiter: requesters A/B, shared output Y, grant status.
interface mux2x1_arbiter_if #(
   parameter int unsigned DATA_W = 8
);
   logic              a_valid;
   logic              a_last;
   logic [DATA_W-1:0] a_data;
   logic              a_ready;

   logic              b_valid;
   logic              b_last;
   logic [DATA_W-1:0] b_data;
   logic              b_ready;

   logic              y_valid;
   logic              y_last;
   logic [DATA_W-1:0] y_data;
   logic              y_ready;

   logic              select;
   logic              busy;

   // Environment side: drives requests and output backpressure.
   modport master (
      output a_valid, a_last, a_data,
      input  a_ready,
      output b_valid, b_last, b_data,
      input  b_ready,
      input  y_valid, y_last, y_data,
      output y_ready,
      input  select, busy
   );

   // Arbiter side.
   modport slave (
      input  a_valid, a_last, a_data,
      output a_ready,
      input  b_valid, b_last, b_data,
      output b_ready,
      output y_valid, y_last, y_data,
      input  y_ready,
      output select, busy
   );
endinterface

// File: rtl/mux2x1_bus.sv
// DATA_W-wide 2:1 steering of data and last, driven by the registered grant.
module mux2x1_bus
   import mux2x1_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic              sel_i,
   input  logic [DATA_W-1:0] a_data_i,
   input  logic              a_last_i,
   input  logic [DATA_W-1:0] b_data_i,
   input  logic              b_last_i,
   output logic [DATA_W-1:0] y_data_o,
   output logic              y_last_o
);

   // Pass the selected requester's payload straight through.
   always_comb begin
      y_data_o = a_data_i;
      y_last_o = a_last_i;
      if (sel_i == SEL_B) begin
         y_data_o = b_data_i;
         y_last_o = b_last_i;
      end
   end

endmodule

// File: rtl/mux2x1_arbiter.sv
// Packet-level 2:1 arbiter: grants one requester, holds the grant until its last beat
// transfers, then rearbitrates after one IDLE cycle.
// Build option: define MUX2X1_ARBITER_RR_EN for round-robin contention resolution;
// left undefined, requester A always wins contention.
module mux2x1_arbiter
   import mux2x1_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   mux2x1_arbiter_if.slave       bus_if
);

   state_e state_q;
   logic   select_q;
   logic   busy_q;
   logic   gnt_a;
   logic   gnt_b;
   logic   last_done;
   logic   prio_sel;
   logic   win_sel;

`ifdef MUX2X1_ARBITER_RR_EN
   logic   ptr_q;
   assign prio_sel = ptr_q;
`else
   assign prio_sel = SEL_A;
`endif

   assign gnt_a = (state_q == GRANT_A);
   assign gnt_b = (state_q == GRANT_B);

   // Only the granted requester sees ready and can raise y_valid.
   assign bus_if.y_valid = (gnt_a & bus_if.a_valid) | (gnt_b & bus_if.b_valid);
   assign bus_if.a_ready = gnt_a & bus_if.y_ready;
   assign bus_if.b_ready = gnt_b & bus_if.y_ready;
   assign bus_if.select  = select_q;
   assign bus_if.busy    = busy_q;

   assign last_done = bus_if.y_valid & bus_if.y_ready & bus_if.y_last;

   mux2x1_bus #(
      .DATA_W (DATA_W)
   ) u_bus (
      .sel_i    (select_q),
      .a_data_i (bus_if.a_data),
      .a_last_i (bus_if.a_last),
      .b_data_i (bus_if.b_data),
      .b_last_i (bus_if.b_last),
      .y_data_o (bus_if.y_data),
      .y_last_o (bus_if.y_last)
   );

   // Pick the winner of an IDLE-cycle arbitration.
   always_comb begin
      win_sel = SEL_A;
      if (bus_if.a_valid && bus_if.b_valid) begin
         win_sel = prio_sel;
      end else if (bus_if.b_valid) begin
         win_sel = SEL_B;
      end
   end

   // Grant FSM with registered select/busy (and priority pointer in round-robin builds).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         select_q <= SEL_A;
         busy_q   <= 1'b0;
`ifdef MUX2X1_ARBITER_RR_EN
         ptr_q    <= SEL_A;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus_if.a_valid || bus_if.b_valid) begin
                  state_q  <= grant_state(win_sel);
                  select_q <= win_sel;
                  busy_q   <= 1'b1;
               end
            end
            GRANT_A, GRANT_B: begin
               if (last_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
`ifdef MUX2X1_ARBITER_RR_EN
                  // Hand priority to the requester that just lost out.
                  ptr_q   <= ~select_q;
`endif
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux2x1_arbiter.sv
// Self-checking bench for mux2x1_arbiter: per-requester expected-beat queues, grant-order log.
module tb_mux2x1_arbiter;
   import mux2x1_pkg::*;

   typedef struct packed {
      logic [7:0] data;
      logic       last;
   } beat_t;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   beat_t q_a[$];
   beat_t q_b[$];
   logic  src_log[$];
   beat_t e_mon;
   int    a_cnt;
   int    b_cnt;
   logic  a_go;
   logic  b_go;
   logic  exp_src;

   mux2x1_arbiter_if #(.DATA_W(8)) bus ();

   mux2x1_arbiter #(
      .DATA_W (8)
   ) u_dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rst_pulse();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   // Scoreboard: every transferred beat must be the next one expected from the granted side.
   always @(negedge clk) begin
      if (!rst && bus.y_valid && bus.y_ready) begin
         src_log.push_back(bus.select);
         if (bus.select == SEL_A) begin
            check_eq("a_beat_expected", 32'(q_a.size() != 0), 1);
            if (q_a.size() != 0) begin
               e_mon = q_a.pop_front();
               check_eq("a_data", 32'(bus.y_data), 32'(e_mon.data));
               check_eq("a_last", 32'(bus.y_last), 32'(e_mon.last));
            end
         end else begin
            check_eq("b_beat_expected", 32'(q_b.size() != 0), 1);
            if (q_b.size() != 0) begin
               e_mon = q_b.pop_front();
               check_eq("b_data", 32'(bus.y_data), 32'(e_mon.data));
               check_eq("b_last", 32'(bus.y_last), 32'(e_mon.last));
            end
         end
      end
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst = 1'b1;
      bus.a_valid = 1'b0; bus.a_last = 1'b0; bus.a_data = 8'h00;
      bus.b_valid = 1'b0; bus.b_last = 1'b0; bus.b_data = 8'h00;
      bus.y_ready = 1'b1;

      // Reset state.
      repeat (2) @(negedge clk);
      check_eq("rst_busy", 32'(bus.busy), 0);
      check_eq("rst_select", 32'(bus.select), 0);
      check_eq("rst_y_valid", 32'(bus.y_valid), 0);
      check_eq("rst_a_ready", 32'(bus.a_ready), 0);
      check_eq("rst_b_ready", 32'(bus.b_ready), 0);
      step();
      rst = 1'b0;

      // Single requester, 3-beat packet.
      step();
      bus.a_valid = 1'b1; bus.a_data = 8'h11; bus.a_last = 1'b0;
      q_a.push_back('{8'h11, 1'b0});
      @(negedge clk);
      check_eq("t1_idle_y_valid", 32'(bus.y_valid), 0);
      check_eq("t1_idle_a_ready", 32'(bus.a_ready), 0);
      check_eq("t1_idle_busy", 32'(bus.busy), 0);
      step();
      @(negedge clk);
      check_eq("t1_grant_busy", 32'(bus.busy), 1);
      check_eq("t1_grant_select", 32'(bus.select), 0);
      check_eq("t1_grant_a_ready", 32'(bus.a_ready), 1);
      step();
      bus.a_data = 8'h22;
      q_a.push_back('{8'h22, 1'b0});
      step();
      bus.a_data = 8'h33; bus.a_last = 1'b1;
      q_a.push_back('{8'h33, 1'b1});
      step();
      bus.a_valid = 1'b0; bus.a_last = 1'b0;
      @(negedge clk);
      check_eq("t1_after_busy", 32'(bus.busy), 0);
      check_eq("t1_after_select", 32'(bus.select), 0);
      check_eq("t1_after_y_valid", 32'(bus.y_valid), 0);

      // Backpressure on a B packet while A waits.
      step();
      bus.b_valid = 1'b1; bus.b_data = 8'hB1; bus.b_last = 1'b0;
      q_b.push_back('{8'hB1, 1'b0});
      step();
      @(negedge clk);
      check_eq("t2_select", 32'(bus.select), 1);
      step();
      bus.b_data = 8'hB2;
      q_b.push_back('{8'hB2, 1'b0});
      bus.y_ready = 1'b0;
      bus.a_valid = 1'b1; bus.a_data = 8'hEE; bus.a_last = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_eq("t2_stall_busy", 32'(bus.busy), 1);
         check_eq("t2_stall_select", 32'(bus.select), 1);
         check_eq("t2_stall_b_ready", 32'(bus.b_ready), 0);
         check_eq("t2_stall_a_ready", 32'(bus.a_ready), 0);
         check_eq("t2_stall_y_data", 32'(bus.y_data), 32'hB2);
         step();
      end
      bus.y_ready = 1'b1;
      step();
      bus.b_data = 8'hB3; bus.b_last = 1'b1;
      q_b.push_back('{8'hB3, 1'b1});
      step();
      bus.b_valid = 1'b0; bus.b_last = 1'b0;
      q_a.push_back('{8'hEE, 1'b1});
      @(negedge clk);
      check_eq("t2_idle_busy", 32'(bus.busy), 0);
      check_eq("t2_idle_y_valid", 32'(bus.y_valid), 0);
      step();
      @(negedge clk);
      check_eq("t2_a_select", 32'(bus.select), 0);
      step();
      bus.a_valid = 1'b0; bus.a_last = 1'b0;

      // Grant lock: A goes quiet between beats while B keeps requesting.
      step();
      bus.a_valid = 1'b1; bus.a_data = 8'hA1; bus.a_last = 1'b0;
      q_a.push_back('{8'hA1, 1'b0});
      step();
      bus.b_valid = 1'b1; bus.b_data = 8'hBB; bus.b_last = 1'b1;
      step();
      bus.a_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("t3_lock_select", 32'(bus.select), 0);
         check_eq("t3_lock_busy", 32'(bus.busy), 1);
         check_eq("t3_lock_y_valid", 32'(bus.y_valid), 0);
         check_eq("t3_lock_b_ready", 32'(bus.b_ready), 0);
         step();
      end
      bus.a_valid = 1'b1; bus.a_data = 8'hA2; bus.a_last = 1'b1;
      q_a.push_back('{8'hA2, 1'b1});
      step();
      bus.a_valid = 1'b0; bus.a_last = 1'b0;
      q_b.push_back('{8'hBB, 1'b1});
      step();
      @(negedge clk);
      check_eq("t3_b_select", 32'(bus.select), 1);
      step();
      bus.b_valid = 1'b0; bus.b_last = 1'b0;

      // Contention with continuous 1-beat packets from both sides, from a fresh pointer.
      rst_pulse();
      src_log.delete();
      for (int i = 0; i < 4; i++) begin
         q_a.push_back('{8'(8'hA0 + i), 1'b1});
         q_b.push_back('{8'(8'hB0 + i), 1'b1});
      end
      a_cnt = 0;
      b_cnt = 0;
      for (int c = 0; c < 40 && (a_cnt < 4 || b_cnt < 4); c++) begin
         bus.a_valid = (a_cnt < 4); bus.a_data = 8'(8'hA0 + a_cnt); bus.a_last = 1'b1;
         bus.b_valid = (b_cnt < 4); bus.b_data = 8'(8'hB0 + b_cnt); bus.b_last = 1'b1;
         @(negedge clk);
         a_go = bus.a_valid & bus.a_ready;
         b_go = bus.b_valid & bus.b_ready;
         step();
         if (a_go) a_cnt++;
         if (b_go) b_cnt++;
      end
      bus.a_valid = 1'b0; bus.a_last = 1'b0;
      bus.b_valid = 1'b0; bus.b_last = 1'b0;
      check_eq("t4_a_done", 32'(a_cnt), 4);
      check_eq("t4_b_done", 32'(b_cnt), 4);
      check_eq("t4_order_len", 32'(src_log.size()), 8);
      for (int i = 0; i < 8 && i < src_log.size(); i++) begin
`ifdef MUX2X1_ARBITER_RR_EN
         exp_src = (i % 2 == 1);
`else
         exp_src = (i >= 4);
`endif
         check_eq($sformatf("t4_order_%0d", i), 32'(src_log[i]), 32'(exp_src));
      end

      // Reset in the middle of a 4-beat A packet.
      step();
      bus.a_valid = 1'b1; bus.a_data = 8'hC1; bus.a_last = 1'b0;
      q_a.push_back('{8'hC1, 1'b0});
      step();
      step();
      bus.a_data = 8'hC2;
      q_a.push_back('{8'hC2, 1'b0});
      step();
      bus.a_data = 8'hC3;
      rst = 1'b1;
      #1;
      check_eq("t5_rst_y_valid", 32'(bus.y_valid), 0);
      check_eq("t5_rst_busy", 32'(bus.busy), 0);
      check_eq("t5_rst_select", 32'(bus.select), 0);
      check_eq("t5_rst_a_ready", 32'(bus.a_ready), 0);
      bus.a_valid = 1'b0;
      bus.b_valid = 1'b1; bus.b_data = 8'hB7; bus.b_last = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      check_eq("t5_post_busy", 32'(bus.busy), 0);
      check_eq("t5_post_y_valid", 32'(bus.y_valid), 0);
      q_b.push_back('{8'hB7, 1'b1});
      step();
      @(negedge clk);
      check_eq("t5_grant_b_select", 32'(bus.select), 1);
      check_eq("t5_grant_b_busy", 32'(bus.busy), 1);
      step();
      bus.b_valid = 1'b0; bus.b_last = 1'b0;
      step();

      check_eq("q_a_drained", 32'(q_a.size()), 0);
      check_eq("q_b_drained", 32'(q_b.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
